motor_ramp: RTL and testbench
=============================

// Module: motor_ramp
// PURPOSE
//  Slew-rate limiter and direction sequencer feeding pwm's duty_cycle input.
//  Accepts speed commands (magnitude + direction) over a valid/ready handshake.
//  Steps duty_cycle toward the target once per pwm period, on pwm's new_dc pulse.
//  Forces duty to 0 plus a dead interval before any direction reversal, so the
//  H-bridge never sees an instant reversal at speed.
// PARAMETERS
//  WIDTH       8    duty/speed width; must equal pwm WIDTH
//  STEP        4    duty increment/decrement per tick; 1..MAX_DUTY
//  DEAD_TICKS  2    ticks held at duty 0 before flipping dir; >=1
//  MAX_DUTY    255  targets above this are clamped to MAX_DUTY
// PORTS
//  clk         in   1      system clock
//  clr         in   1      asynchronous active-high reset
//  cmd_speed   in   WIDTH  target duty magnitude
//  cmd_dir     in   1      target direction; 1 = forward
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      command can be accepted this cycle
//  new_dc      in   1      tick from pwm, one cycle wide, once per period
//  estop       in   1      synchronous emergency stop, level sensitive
//  duty_cycle  out  WIDTH  to pwm duty_cycle, registered
//  dir         out  1      to bridge direction pin, registered
//  at_target   out  1      state==HOLD
// BEHAVIOUR
//  Reset (clr high, async): state=HOLD, duty_cycle=0, dir=0, tgt=0, tgt_dir=0,
//   dead_cnt=0. After reset: cmd_ready=1, at_target=1.
//  Accept: cmd_valid & cmd_ready at a clock edge.
//   - tgt <= min(cmd_speed, MAX_DUTY); tgt_dir <= cmd_dir.
//   - A new accept overwrites the previous target, even mid-ramp.
//   - The new target takes effect from the next cycle. A tick in the accept
//     cycle uses the old target.
//  cmd_ready = 1 in HOLD, UP and DOWN; 0 in DEAD and ESTOP.
//  Effective goal each cycle:
//   - tgt_dir != dir and tgt != 0: goal = 0, reversal pending.
//   - tgt == 0: goal = 0 and dir is never changed.
//   - Otherwise: goal = tgt.
//  States (evaluated every cycle, duty updated only on new_dc):
//   HOLD : duty==goal and no reversal pending.
//          -> UP if duty<goal; -> DOWN if duty>goal; -> DEAD if duty==0 and
//          reversal pending.
//   UP   : on tick, duty <= min(duty+STEP, goal). Sum computed in WIDTH+1 bits,
//          so no wrap at 255.
//          -> HOLD when duty==goal; -> DOWN if goal drops below duty.
//   DOWN : on tick, duty <= (duty >= goal+STEP) ? duty-STEP : goal. Compare in
//          WIDTH+1 bits, no underflow.
//          -> DEAD when duty reaches 0 with reversal pending; else -> HOLD at
//          goal; -> UP if goal rises above duty.
//   DEAD : duty held at 0; dead_cnt increments per tick.
//          When dead_cnt==DEAD_TICKS: dir <= tgt_dir, dead_cnt <= 0, then
//          -> UP (tgt>0).
//   ESTOP: entered from any state the cycle after estop is sampled high.
//          duty_cycle <= 0 on that same edge, not tick-aligned. dir unchanged.
//          Exit the first cycle estop is sampled low: tgt <= 0, -> HOLD.
//          estop has priority over a simultaneous accept; that command is
//          dropped (cmd_ready=0).
//  Latency: duty_cycle changes on the clock edge after the cycle new_dc is
//   high, which lands inside pwm's final chunk before the period wraps.
//  Ticks never change duty by more than STEP, except the ESTOP drop to 0.
//  dir only changes while duty_cycle==0.
//  Reset mid-ramp: immediate return to reset values; no tick needed.
// TESTING
//  1 Reset, accept (200,fwd), tick every 16 clk -> duty 0,4,..,196,200 after
//    50 ticks; at_target=1; dir=1.
//  2 From 200 fwd, accept (100,fwd) -> duty 196..100 by 4/tick, holds 100.
//  3 From 100 fwd, accept (60,rev) -> ramp to 0; 2 ticks at 0 with
//    cmd_ready=0; dir 1->0; ramp to 60.
//  4 From 252, accept 255 -> 253? no: min(256,255)=255, no wrap.
//    MAX_DUTY=200 with cmd 250 -> holds 200.
//  5 estop high mid-ramp at duty 120 -> duty 0 next edge, cmd_ready=0.
//    estop low -> HOLD at 0.
//  6 cmd accept and new_dc in same cycle -> that tick steps toward old target.
//    Async clr asserted between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/motor_ramp.sv
// Slew-rate limiter and direction sequencer for the pwm duty_cycle input.
// Ramps duty by STEP per pwm tick and inserts a zero-duty dead interval before reversals.
module motor_ramp #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 2,
    parameter int MAX_DUTY   = 255
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] cmd_speed,
    input  logic             cmd_dir,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             new_dc,
    input  logic             estop,
    output logic [WIDTH-1:0] duty_cycle,
    output logic             dir,
    output logic             at_target
);

    localparam int CNT_W = $clog2(DEAD_TICKS + 1);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_D  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_D   = WIDTH'(MAX_DUTY);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEAD_TICKS);

    typedef enum logic [2:0] {HOLD, UP, DOWN, DEAD, ESTOP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] duty_nxt, tgt, tgt_nxt, goal;
    logic             dir_nxt, tgt_dir, tgt_dir_nxt;
    logic             rev_pend, accept;
    logic [CNT_W-1:0] dead_cnt, dead_cnt_nxt;

    // Sum is formed one bit wider so a step near full scale cannot wrap.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] g);
        logic [WIDTH:0] s;
        s = {1'b0, d} + STEP_X;
        return (s > {1'b0, g}) ? g : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] g);
        logic [WIDTH:0] lim;
        lim = {1'b0, g} + STEP_X;
        return ({1'b0, d} >= lim) ? (d - STEP_D) : g;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_tgt(input logic [WIDTH-1:0] c);
        return (c > MAX_D) ? MAX_D : c;
    endfunction

    assign cmd_ready = ((state == HOLD) || (state == UP) || (state == DOWN)) && !estop;
    assign accept    = cmd_valid && cmd_ready;
    assign at_target = (state == HOLD);
    // A zero target never flips dir, so only a non-zero target can request a reversal.
    assign rev_pend  = (tgt_dir != dir) && (tgt != '0);
    assign goal      = rev_pend ? '0 : tgt;

    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty_cycle;
        dir_nxt      = dir;
        tgt_nxt      = tgt;
        tgt_dir_nxt  = tgt_dir;
        dead_cnt_nxt = dead_cnt;

        if (accept) begin
            tgt_nxt     = clamp_tgt(cmd_speed);
            tgt_dir_nxt = cmd_dir;
        end

        if (estop) begin
            state_nxt    = ESTOP;
            duty_nxt     = '0;
            dead_cnt_nxt = '0;
        end else begin
            case (state)
                HOLD, UP, DOWN: begin
                    if ((state != HOLD) && new_dc) begin
                        if (duty_cycle < goal)
                            duty_nxt = step_up(duty_cycle, goal);
                        else if (duty_cycle > goal)
                            duty_nxt = step_down(duty_cycle, goal);
                    end
                    if (rev_pend && (duty_cycle == '0))
                        state_nxt = DEAD;
                    else if (duty_cycle < goal)
                        state_nxt = UP;
                    else if (duty_cycle > goal)
                        state_nxt = DOWN;
                    else
                        state_nxt = HOLD;
                end
                DEAD: begin
                    duty_nxt = '0;
                    if (dead_cnt == CNT_END) begin
                        dir_nxt      = tgt_dir;
                        dead_cnt_nxt = '0;
                        state_nxt    = UP;
                    end else if (new_dc) begin
                        dead_cnt_nxt = dead_cnt + CNT_W'(1);
                    end
                end
                ESTOP: begin
                    tgt_nxt   = '0;
                    state_nxt = HOLD;
                end
                default: state_nxt = HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= HOLD;
            duty_cycle <= '0;
            dir        <= 1'b0;
            tgt        <= '0;
            tgt_dir    <= 1'b0;
            dead_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            duty_cycle <= duty_nxt;
            dir        <= dir_nxt;
            tgt        <= tgt_nxt;
            tgt_dir    <= tgt_dir_nxt;
            dead_cnt   <= dead_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp: table of ramp segments plus hand sequences
// for estop, accept-with-tick, MAX_DUTY clamping and asynchronous clear.
module tb_motor_ramp;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] cmd_speed = '0;
    logic       cmd_dir = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       new_dc = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] duty_cycle;
    logic       dir;
    logic       at_target;

    logic [7:0] cmd_speed2 = '0;
    logic       cmd_dir2 = 1'b0;
    logic       cmd_valid2 = 1'b0;
    logic       cmd_ready2;
    logic [7:0] duty2;
    logic       dir2;
    logic       at_target2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_ramp #(.WIDTH(8), .STEP(4), .DEAD_TICKS(2), .MAX_DUTY(255)) dut (
        .clk(clk), .clr(clr), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .new_dc(new_dc),
        .estop(estop), .duty_cycle(duty_cycle), .dir(dir), .at_target(at_target)
    );

    motor_ramp #(.WIDTH(8), .STEP(4), .DEAD_TICKS(2), .MAX_DUTY(200)) dut2 (
        .clk(clk), .clr(clr), .cmd_speed(cmd_speed2), .cmd_dir(cmd_dir2),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .new_dc(new_dc),
        .estop(estop), .duty_cycle(duty2), .dir(dir2), .at_target(at_target2)
    );

    // speed/dir: command; start: duty before; ndn: down ticks ending at mid;
    // ndead: ticks spent at zero; nup: up ticks from mid to fin.
    typedef struct {
        int speed;
        bit dir;
        int start;
        int ndn;
        int mid;
        int ndead;
        int nup;
        int fin;
        bit exp_dir;
    } row_t;

    row_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int gap);
        new_dc = 1'b1;
        @(negedge clk);
        new_dc = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic accept(input int spd, input bit d);
        cmd_speed = 8'(spd);
        cmd_dir   = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_row(input row_t r);
        int e;
        chk("row_ready", cmd_ready, 1);
        accept(r.speed, r.dir);
        for (int k = 1; k <= r.ndn; k++) begin
            tick(16);
            e = r.start - 4 * k;
            if (e < r.mid) e = r.mid;
            chk("ramp_down", duty_cycle, e);
        end
        for (int k = 0; k < r.ndead; k++) begin
            chk("dead_ready", cmd_ready, 0);
            chk("dead_duty", duty_cycle, 0);
            chk("dead_dir", dir, r.exp_dir ? 0 : 1);
            tick(16);
        end
        for (int k = 1; k <= r.nup; k++) begin
            tick(16);
            e = r.mid + 4 * k;
            if (e > r.fin) e = r.fin;
            chk("ramp_up", duty_cycle, e);
        end
        chk("row_at_target", at_target, 1);
        chk("row_duty", duty_cycle, r.fin);
        chk("row_dir", dir, r.exp_dir);
    endtask

    initial begin
        int e;
        tbl[0] = '{200, 1'b1, 0,   0,  0,   2, 50, 200, 1'b1};
        tbl[1] = '{100, 1'b1, 200, 25, 100, 0, 0,  100, 1'b1};
        tbl[2] = '{60,  1'b0, 100, 25, 0,   2, 15, 60,  1'b0};
        tbl[3] = '{255, 1'b0, 20,  0,  20,  0, 59, 255, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_dir", dir, 0);
        chk("rst_at_target", at_target, 1);
        chk("rst_ready", cmd_ready, 1);
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_row(tbl[i]);

        // estop in the middle of an up-ramp at duty 120
        accept(160, 1'b0);
        repeat (15) tick(16);
        chk("pre_estop_duty", duty_cycle, 120);
        estop     = 1'b1;
        cmd_speed = 8'd250;
        cmd_dir   = 1'b0;
        cmd_valid = 1'b1;
        #1;
        chk("estop_ready_comb", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("estop_duty", duty_cycle, 0);
        chk("estop_dir", dir, 0);
        chk("estop_at_target", at_target, 0);
        chk("estop_ready", cmd_ready, 0);
        tick(16);
        chk("estop_tick_duty", duty_cycle, 0);
        estop = 1'b0;
        @(negedge clk);
        chk("estop_exit_hold", at_target, 1);
        chk("estop_exit_ready", cmd_ready, 1);
        tick(16);
        tick(16);
        chk("estop_exit_duty", duty_cycle, 0);

        // tick in the accept cycle still steps toward the old target
        accept(200, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick(16);
            chk("pre_retarget", duty_cycle, 4 * k);
        end
        cmd_speed = 8'd20;
        cmd_dir   = 1'b0;
        cmd_valid = 1'b1;
        new_dc    = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        new_dc    = 1'b0;
        repeat (14) @(negedge clk);
        chk("tick_old_target", duty_cycle, 44);
        for (int k = 1; k <= 6; k++) begin
            tick(16);
            e = 44 - 4 * k;
            if (e < 20) e = 20;
            chk("retarget_down", duty_cycle, e);
        end
        chk("retarget_hold", at_target, 1);

        // up-ramp into full scale: 252 -> 255 must not wrap
        run_row(tbl[3]);

        // MAX_DUTY = 200 instance clamps a 250 command
        cmd_speed2 = 8'd250;
        cmd_dir2   = 1'b1;
        cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("clamp_dead_ready", cmd_ready2, 0);
            tick(4);
        end
        for (int k = 1; k <= 53; k++) begin
            tick(4);
            e = 4 * k;
            if (e > 200) e = 200;
            chk("clamp_ramp", duty2, e);
        end
        chk("clamp_at_target", at_target2, 1);
        chk("clamp_dir", dir2, 1);
        chk("main_unaffected", duty_cycle, 255);

        // asynchronous clear between edges
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        chk("clr_duty", duty_cycle, 0);
        chk("clr_dir2", dir2, 0);
        chk("clr_duty2", duty2, 0);
        chk("clr_at_target", at_target, 1);
        chk("clr_ready", cmd_ready, 1);
        @(negedge clk);
        clr = 1'b0;
        tick(16);
        chk("post_clr_duty", duty_cycle, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
